// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned OVERSAMPLE     = 16;
    // 50 MHz / (16 * 19200)
    localparam int unsigned DVSR_19200_50M = 163;

    // Parity over the low dbit bits; odd mode inverts the plain XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned dbit,
                                        input int unsigned mode);
        logic x;
        x = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < dbit) x ^= data[i];
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running mod-M counter producing a one-clk max_tick every M clocks.
module uart_baud_gen #(
    parameter int unsigned M = 163
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(M - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = (count == C_LAST) ? '0 : count + CW'(1);
    end

    // max_tick is high during the cycle in which count sits at M-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            max_tick <= 1'(M == 1);
        end else begin
            count    <= count_nxt;
            max_tick <= (count_nxt == C_LAST);
        end
    end

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmitter: start, DBIT data bits LSB-first, optional parity, stop; 16 ticks per bit.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DVSR    = DVSR_19200_50M,
    parameter int unsigned PARITY  = PAR_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int unsigned NW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int unsigned BW = $clog2(DBIT);
    localparam logic [NW-1:0] N_BIT_LAST  = NW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_STOP_LAST = NW'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST      = BW'(DBIT - 1);

    tx_state_t       state;
    logic [NW-1:0]   n;
    logic [BW-1:0]   b;
    logic [DBIT-1:0] shift;
    logic            par_bit;
    logic            s_tick;

    uart_baud_gen #(
        .M(DVSR)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .max_tick(s_tick)
    );

    // tx is set on the same edge as each state/bit change so the line never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            n            <= '0;
            b            <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shift   <= din[DBIT-1:0];
                        par_bit <= parity_bit(din, DBIT, PARITY);
                        n       <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (n == N_BIT_LAST) begin
                            n     <= '0;
                            b     <= '0;
                            tx    <= shift[0];
                            state <= ST_DATA;
                        end else begin
                            n <= n + NW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (n == N_BIT_LAST) begin
                            n     <= '0;
                            shift <= shift >> 1;
                            if (b == B_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    tx    <= par_bit;
                                    state <= ST_PARITY;
                                end else begin
                                    tx    <= 1'b1;
                                    state <= ST_STOP;
                                end
                            end else begin
                                b  <= b + BW'(1);
                                tx <= shift[1];
                            end
                        end else begin
                            n <= n + NW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (n == N_BIT_LAST) begin
                            n     <= '0;
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            n <= n + NW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // The done cycle is still spent in stop, so a same-cycle tx_start is dropped
                    if (tx_done_tick) begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (s_tick) begin
                        if (n == N_STOP_LAST) begin
                            n            <= '0;
                            tx_done_tick <= 1'b1;
                        end else begin
                            n <= n + NW'(1);
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Randomized self-checking bench for uart_tx_ser against a frame-level line model.
module tb_uart_tx_ser;

    localparam int D  = 2;
    localparam int DB = 8;
    localparam int NI = 4;

    typedef logic bitq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start [NI];
    logic [7:0] din      [NI];
    logic       tx       [NI];
    logic       busy     [NI];
    logic       done     [NI];

    int par_cfg [NI] = '{0, 2, 1, 0};
    int sb_cfg  [NI] = '{16, 16, 16, 32};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_ser #(.DBIT(DB), .SB_TICK(16), .DVSR(D), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start[0]), .din(din[0]),
        .tx_busy(busy[0]), .tx_done_tick(done[0]), .tx(tx[0]));
    uart_tx_ser #(.DBIT(DB), .SB_TICK(16), .DVSR(D), .PARITY(2)) u_dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start[1]), .din(din[1]),
        .tx_busy(busy[1]), .tx_done_tick(done[1]), .tx(tx[1]));
    uart_tx_ser #(.DBIT(DB), .SB_TICK(16), .DVSR(D), .PARITY(1)) u_dut2 (
        .clk(clk), .reset(reset), .tx_start(tx_start[2]), .din(din[2]),
        .tx_busy(busy[2]), .tx_done_tick(done[2]), .tx(tx[2]));
    uart_tx_ser #(.DBIT(DB), .SB_TICK(32), .DVSR(D), .PARITY(0)) u_dut3 (
        .clk(clk), .reset(reset), .tx_start(tx_start[3]), .din(din[3]),
        .tx_busy(busy[3]), .tx_done_tick(done[3]), .tx(tx[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level per bit period: start, data LSB-first, parity, one entry per 16 stop ticks
    function automatic bitq_t frame_bits(input logic [7:0] data, input int par, input int sb);
        bitq_t q;
        logic [DB-1:0] d;
        int ones;
        d    = data[DB-1:0];
        ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(d[i]);
        if (par == 2) q.push_back(ones % 2 == 1);
        if (par == 1) q.push_back(ones % 2 == 0);
        for (int s = 0; s < sb / 16; s++) q.push_back(1'b1);
        return q;
    endfunction

    // post: 0 = idle afterwards, 1 = strobe during the done cycle (must be ignored),
    //       2 = arm tx_start with nxt on the cycle after done and return
    task automatic run_frame(input int idx, input logic [7:0] data, input bit armed,
                             input bit repulse, input int post, input logic [7:0] nxt,
                             output int done_at);
        bitq_t exp_q;
        int f_ticks;
        int limit;
        int done_cyc = -1;
        int busy_cnt = 0;
        int done_cnt = 0;
        int bad_idle = 0;
        int k;
        logic [7:0] rx = '0;
        exp_q   = frame_bits(data, par_cfg[idx], sb_cfg[idx]);
        f_ticks = (1 + DB + ((par_cfg[idx] != 0) ? 1 : 0)) * 16 + sb_cfg[idx];
        limit   = f_ticks * D + 48;
        if (!armed) begin
            @(negedge clk);
            din[idx]      = data;
            tx_start[idx] = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_start[idx] = 1'b0;
        if (busy[idx] === 1'b1) busy_cnt++;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(posedge clk);
            #1;
            if (busy[idx] === 1'b1) busy_cnt++;
            if (done[idx] === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc >= 8 * D && (cyc - 8 * D) % (16 * D) == 0) begin
                k = (cyc - 8 * D) / (16 * D);
                if (k < exp_q.size()) begin
                    check($sformatf("i%0d_bit%0d", idx, k), 32'(tx[idx]), 32'(exp_q[k]));
                    if (k >= 1 && k <= DB) rx[k-1] = tx[idx];
                end
            end
            if (repulse && cyc == 8 * D + 16 * D * 4) begin
                din[idx]      = 8'hFF;
                tx_start[idx] = 1'b1;
            end else if (repulse && cyc == 8 * D + 16 * D * 4 + 1) begin
                tx_start[idx] = 1'b0;
            end
            if (done_cyc >= 0 && cyc == done_cyc && post == 1) begin
                din[idx]      = 8'h55;
                tx_start[idx] = 1'b1;
            end
            if (done_cyc >= 0 && cyc > done_cyc) begin
                if (cyc == done_cyc + 1) tx_start[idx] = 1'b0;
                if (tx[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) bad_idle++;
                if (post == 2) begin
                    check($sformatf("i%0d_gap_tx", idx), 32'(tx[idx]), 32'd1);
                    din[idx]      = nxt;
                    tx_start[idx] = 1'b1;
                    break;
                end
                if (cyc == done_cyc + 40) break;
            end
        end
        done_at = done_cyc;
        check($sformatf("i%0d_done_seen", idx), 32'(done_cyc >= 0), 32'd1);
        check($sformatf("i%0d_done_pulses", idx), 32'(done_cnt), 32'd1);
        check($sformatf("i%0d_done_window", idx),
              32'(done_cyc >= f_ticks * D - D && done_cyc <= f_ticks * D), 32'd1);
        check($sformatf("i%0d_busy_len", idx), 32'(busy_cnt), 32'(done_cyc + 1));
        check($sformatf("i%0d_rx_byte", idx), 32'(rx), 32'(data));
        check($sformatf("i%0d_idle_after", idx), 32'(bad_idle), 32'd0);
    endtask

    initial begin
        int d0;
        int d3;
        int dummy;
        logic [7:0] rnd;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tx_start[i] = 1'b0;
            din[i]      = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d_rst_tx", i), 32'(tx[i]), 32'd1);
            check($sformatf("i%0d_rst_busy", i), 32'(busy[i]), 32'd0);
            check($sformatf("i%0d_rst_done", i), 32'(done[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(0, 8'hA5, 1'b0, 1'b0, 0, 8'h00, d0);
        run_frame(1, 8'h07, 1'b0, 1'b0, 0, 8'h00, dummy);
        run_frame(2, 8'h07, 1'b0, 1'b0, 0, 8'h00, dummy);
        run_frame(0, 8'hA5, 1'b0, 1'b1, 0, 8'h00, dummy);
        run_frame(0, 8'hA5, 1'b0, 1'b0, 1, 8'h00, dummy);
        run_frame(0, 8'hA5, 1'b0, 1'b0, 2, 8'h3C, dummy);
        run_frame(0, 8'h3C, 1'b1, 1'b0, 0, 8'h00, dummy);
        run_frame(3, 8'hA5, 1'b0, 1'b0, 0, 8'h00, d3);
        check("sb32_extra_delay", 32'(d3 - d0 >= 16 * D - D && d3 - d0 <= 16 * D + D), 32'd1);

        // Abort mid data bit 3 (A5 bit 3 is 0, so the line visibly returns high)
        @(negedge clk);
        din[0]      = 8'hA5;
        tx_start[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        repeat (8 * D + 16 * D * 4) @(posedge clk);
        #1;
        check("abort_pre_tx", 32'(tx[0]), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("abort_async_tx", 32'(tx[0]), 32'd1);
        check("abort_async_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(0, 8'($urandom), 1'b0, 1'b0, 0, 8'h00, dummy);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NI; i++) begin
                rnd = 8'($urandom);
                repeat ($urandom_range(1, 12)) @(negedge clk);
                run_frame(i, rnd, 1'b0, 1'b0, 0, 8'h00, dummy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
